fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 16, meaning the number of instruction-memory words.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC loaded on reset.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low; one clock only.
REQ-005 SHALL have port run  input  1  starts fetching from IDLE.
REQ-006 SHALL have port address  output  16  instruction address to imem, equal to PC.
REQ-007 SHALL have port im_select  output  1  fetch strobe to imem.
REQ-008 SHALL have port opcode  input  4  returned opcode field.
REQ-009 SHALL have port jump  input  12  returned jump target field.
REQ-010 SHALL have port jiz  input  8  returned jump-if-zero target field.
REQ-011 SHALL have port zero_flag  input  1  ALU zero result, sampled at issue acceptance.
REQ-012 SHALL have port instr_valid  output  1  captured instruction offered to execute stage.
REQ-013 SHALL have port instr_ready  input  1  execute stage accepts instruction.
REQ-014 SHALL have port halted  output  1  HALT opcode retired.
REQ-015 SHALL have port fault  output  1  out-of-range fetch target; only with FETCH_BOUNDS_EN.

Function
REQ-016 SHALL implement states IDLE, REQ, CAPT, ISSUE, HALT (plus FAULT under FETCH_BOUNDS_EN).
REQ-017 IDLE SHALL move to REQ on run=1; otherwise hold.
REQ-018 REQ SHALL drive im_select=1 with address=PC for exactly one cycle, then go to CAPT.
REQ-019 CAPT SHALL drive im_select=0, register opcode/jump/jiz, then go to ISSUE; im_select SHALL return low between every fetch.
REQ-020 ISSUE SHALL hold instr_valid=1 with stable captured fields until instr_ready=1; the next PC SHALL be computed in the accepting cycle.
REQ-021 Next PC: opcode 4'b1000 (JMP) -> zero-extended jump; 4'b1001 (JIZ) -> zero-extended jiz if zero_flag=1, else PC+1; 4'b1111 (HALT) -> PC unchanged, go to HALT; any other opcode -> PC+1.
REQ-022 After a non-HALT acceptance, the state SHALL be REQ; minimum throughput is one instruction per 3 cycles.
REQ-023 PC+1 from IMEM_DEPTH-1 SHALL wrap to 0.
REQ-024 HALT SHALL assert halted=1, keep im_select=0 and instr_valid=0, and be left only by reset.
REQ-025 run deasserted after leaving IDLE SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, PC=RESET_PC, and im_select, instr_valid, halted, fault = 0, captured fields = 0, including mid-fetch or mid-ISSUE.
REQ-027 After rst_n rises, the first im_select pulse SHALL occur no earlier than the second rising edge after run=1 is sampled.

Configuration
REQ-028 With macro FETCH_BOUNDS_EN defined, a computed next PC >= IMEM_DEPTH SHALL go to FAULT (fault=1, no further fetches, exit only by reset); sequential wrap per REQ-023 is not a fault.
REQ-029 Without FETCH_BOUNDS_EN, out-of-range targets SHALL be reduced modulo IMEM_DEPTH, and fault SHALL be tied 0.

Structure
REQ-030 A shared package SHALL hold the opcode constants (JMP, JIZ, HALT) and the state enumeration.
REQ-031 The next-PC computation SHALL be a sub-module named fetch_next_pc (combinational); the FSM and registers stay in fetch_unit.

Verification
REQ-032 Reset then run=1, ready always 1, NOP opcodes -> im_select pulses at addresses 0,1,2 every 3 cycles.
REQ-033 At PC=3 return opcode 1000, jump=12'h007 -> next fetch address 7.
REQ-034 JIZ jiz=8'h05 with zero_flag=1 -> next address 5; with zero_flag=0 at PC=4 -> next address 5 via PC+1, proven by also testing at PC=2 -> 3.
REQ-035 instr_ready held 0 for 4 cycles -> instr_valid and fields stable, no im_select pulse; ready=1 -> fetch resumes next cycle.
REQ-036 PC=15 NOP -> address 0; JMP jump=12'h020 -> fault=1 with FETCH_BOUNDS_EN, address 0 without.
REQ-037 rst_n low during ISSUE -> outputs 0 immediately; opcode 1111 -> halted=1, no further im_select.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared opcode constants and FSM state encoding for the fetch unit.
// The fault state is only reachable when FETCH_BOUNDS_EN is defined.
package fetch_unit_pkg;

  localparam logic [3:0] OpJmp  = 4'b1000;
  localparam logic [3:0] OpJiz  = 4'b1001;
  localparam logic [3:0] OpHalt = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCapt,
    StIssue,
    StHalt,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the fetch unit.
// With FETCH_BOUNDS_EN an out-of-range flag is produced; otherwise targets wrap modulo depth.
module fetch_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 16
) (
  input  logic [15:0] pc,
  input  logic [3:0]  opcode,
  input  logic [11:0] jump,
  input  logic [7:0]  jiz,
  input  logic        zero_flag,
  output logic [15:0] next_pc,
  output logic        is_halt
`ifdef FETCH_BOUNDS_EN
  ,
  output logic        out_of_range
`endif
);

  localparam logic [15:0] LastPc = 16'(IMEM_DEPTH - 1);
  localparam logic [16:0] DepthW = 17'(IMEM_DEPTH);

  logic [16:0] target;

  always_comb begin
    is_halt = (opcode == OpHalt);
    target  = '0;
    if (opcode == OpJmp) begin
      target = {5'b0, jump};
    end else if (opcode == OpJiz && zero_flag) begin
      target = {9'b0, jiz};
    end else if (is_halt) begin
      target = {1'b0, pc};
    end else begin
      // Sequential advance wraps at the end of memory and is never a fault.
      target = (pc == LastPc) ? 17'd0 : {1'b0, pc} + 17'd1;
    end
  end

`ifdef FETCH_BOUNDS_EN
  assign out_of_range = !is_halt && (target >= DepthW);
  assign next_pc      = target[15:0];
`else
  assign next_pc      = 16'(target % DepthW);
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: request, capture, issue with ready handshake, halt.
// Define FETCH_BOUNDS_EN to trap out-of-range jump targets in a FAULT state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [15:0] address,
  output logic        im_select,
  input  logic [3:0]  opcode,
  input  logic [11:0] jump,
  input  logic [7:0]  jiz,
  input  logic        zero_flag,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic        fault
);

  fetch_state_e state_q, state_d;

  logic [15:0] pc_q;
  logic [3:0]  op_q;
  logic [11:0] jump_q;
  logic [7:0]  jiz_q;
  logic [15:0] next_pc;
  logic        is_halt;
  logic        accept;
  logic        pc_load;

`ifdef FETCH_BOUNDS_EN
  logic out_of_range;
`endif

  fetch_next_pc #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_next_pc (
    .pc       (pc_q),
    .opcode   (op_q),
    .jump     (jump_q),
    .jiz      (jiz_q),
    .zero_flag(zero_flag),
    .next_pc  (next_pc),
    .is_halt  (is_halt)
`ifdef FETCH_BOUNDS_EN
    ,
    .out_of_range(out_of_range)
`endif
  );

  assign accept = (state_q == StIssue) && instr_ready;

`ifdef FETCH_BOUNDS_EN
  assign pc_load = accept && !out_of_range;
`else
  assign pc_load = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StReq;
      StReq:   state_d = StCapt;
      StCapt:  state_d = StIssue;
      StIssue: begin
        if (instr_ready) begin
          if (is_halt) begin
            state_d = StHalt;
`ifdef FETCH_BOUNDS_EN
          end else if (out_of_range) begin
            state_d = StFault;
`endif
          end else begin
            state_d = StReq;
          end
        end
      end
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    im_select   = (state_q == StReq);
    instr_valid = (state_q == StIssue);
    halted      = (state_q == StHalt);
  end

`ifdef FETCH_BOUNDS_EN
  assign fault = (state_q == StFault);
`else
  assign fault = 1'b0;
`endif

  // Fields are latched at the end of CAPT so they stay stable through a stalled ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      op_q   <= '0;
      jump_q <= '0;
      jiz_q  <= '0;
    end else begin
      if (state_q == StCapt) begin
        op_q   <= opcode;
        jump_q <= jump;
        jiz_q  <= jiz;
      end
      if (pc_load) begin
        pc_q <= next_pc;
      end
    end
  end

  assign address = pc_q;

endmodule
